// File: rtl/fft_pkg.sv
// Shared constants, sample type, read-state encoding and index helpers for the 16-point FFT.
package fft_pkg;

  localparam int unsigned FFT_N     = 16;
  localparam int unsigned FFT_LOG2N = 4;
  localparam int unsigned FFT_DW    = 16;

  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
  } fft_cplx_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// Two-bank frame register file: one write port, one asynchronous read port; address MSB selects the bank.
module fft_frame_bank #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rd_data_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [0:DEPTH-1];

  // Contents need no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_data_c = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong output reorder buffer for the 16-point FFT with push/stall handshakes.
// FFT_OUT_BITREV_EN: when defined, frames are re-emitted in bit-reversed index order.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int unsigned DW = FFT_DW,
  parameter int unsigned N  = FFT_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_push,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          in_stall,
  output logic          out_push,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          out_last,
  input  logic          out_stall,
  output logic          ovf
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned WW = 2 * DW;

  rd_state_t     state, state_nxt;
  logic [1:0]    full, full_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic [CW-1:0] wr_cnt, wr_cnt_nxt;
  logic [CW-1:0] rd_cnt, rd_cnt_nxt;
  logic          out_push_nxt, out_last_nxt, in_stall_nxt, ovf_nxt;
  logic [DW-1:0] out_real_nxt, out_imag_nxt;

  logic          wr_accept, last_xfer, load;
  logic          rd_sel_bank;
  logic [CW-1:0] rd_sel_cnt, rd_idx;
  logic [WW-1:0] rd_data;

  assign wr_accept = in_push & ~in_stall;
  assign last_xfer = (state == RD_STREAM) & out_push & out_last & ~out_stall;

  // On a last-sample transfer the next read already targets the other bank, so frames run back to back.
  assign rd_sel_bank = last_xfer ? ~rd_bank : rd_bank;
  assign rd_sel_cnt  = last_xfer ? '0 : rd_cnt;

`ifdef FFT_OUT_BITREV_EN
  assign rd_idx = bitrev4(rd_sel_cnt);
`else
  assign rd_idx = rd_sel_cnt;
`endif

  fft_frame_bank #(
    .W  (WW),
    .AW (CW + 1)
  ) u_bank (
    .clk       (clk),
    .we        (wr_accept),
    .waddr     ({wr_bank, wr_cnt}),
    .wdata     ({in_real, in_imag}),
    .raddr     ({rd_sel_bank, rd_idx}),
    .rd_data_c (rd_data)
  );

  // Next-state logic for write pointer, bank flags and read FSM/output register.
  always_comb begin
    state_nxt    = state;
    full_nxt     = full;
    wr_bank_nxt  = wr_bank;
    rd_bank_nxt  = rd_bank;
    wr_cnt_nxt   = wr_cnt;
    rd_cnt_nxt   = rd_cnt;
    out_push_nxt = out_push;
    out_real_nxt = out_real;
    out_imag_nxt = out_imag;
    out_last_nxt = out_last;
    ovf_nxt      = ovf | (in_push & in_stall);
    load         = 1'b0;

    if (wr_accept) begin
      wr_cnt_nxt = CW'(wr_cnt + 1'b1);
      if (wr_cnt == CW'(N - 1)) begin
        full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt       = ~wr_bank;
      end
    end

    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          load      = 1'b1;
          state_nxt = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (out_push && out_last) begin
          if (!out_stall) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
            if (full[~rd_bank]) begin
              load = 1'b1;
            end else begin
              state_nxt    = RD_IDLE;
              out_push_nxt = 1'b0;
              out_last_nxt = 1'b0;
            end
          end
        end else if (!out_push || !out_stall) begin
          load = 1'b1;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase

    if (load) begin
      out_push_nxt                 = 1'b1;
      {out_real_nxt, out_imag_nxt} = rd_data;
      out_last_nxt                 = (rd_sel_cnt == CW'(N - 1));
      rd_cnt_nxt                   = CW'(rd_sel_cnt + 1'b1);
    end

    in_stall_nxt = full_nxt[wr_bank_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RD_IDLE;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      out_push <= 1'b0;
      out_real <= '0;
      out_imag <= '0;
      out_last <= 1'b0;
      in_stall <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      rd_bank  <= rd_bank_nxt;
      wr_cnt   <= wr_cnt_nxt;
      rd_cnt   <= rd_cnt_nxt;
      out_push <= out_push_nxt;
      out_real <= out_real_nxt;
      out_imag <= out_imag_nxt;
      out_last <= out_last_nxt;
      in_stall <= in_stall_nxt;
      ovf      <= ovf_nxt;
    end
  end

endmodule
